// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pixel type and pixel-buffer FSM encoding
package vga_pkg;

  localparam int HFP    = 40;
  localparam int HPULSE = 48;
  localparam int HBP    = 40;
  localparam int VFP    = 13;
  localparam int VPULSE = 3;
  localparam int VBP    = 29;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    SYNC,
    ARM,
    RUN,
    STARVE
  } pixbuf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO; head word is always visible on rd_data
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;
  assign empty   = (r_wr_ptr == r_rd_ptr);
  // The extra pointer bit separates the wrapped-full case from empty.
  assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_buffer.sv
// rtl/vga_pixel_buffer.sv - frame-aligned pixel buffer in front of the VGA pixel path
// Defining VGA_PIXBUF_STATS_EN adds saturating underrun and frame counters.
module vga_pixel_buffer
  import vga_pkg::*;
#(
  parameter int   HDISP    = 800,
  parameter int   VDISP    = 480,
  parameter int   DEPTH    = 1024,
  parameter rgb_t FILL_RGB = 24'h000000
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        blank_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        blank_o,
  output logic [23:0] rgb_o,
  output logic        underrun_o,
  output logic        misalign_o
`ifdef VGA_PIXBUF_STATS_EN
  ,
  output logic [15:0] underrun_cnt_o,
  output logic [15:0] frame_cnt_o
`endif
);

  localparam int            NPIX     = HDISP * VDISP;
  localparam int            CW       = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);
  localparam int            EW       = $bits(rgb_t) + 1;

  pixbuf_state_t r_state;
  pixbuf_state_t w_state_nxt;
  logic [CW-1:0] r_pix_cnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic          r_armed;
  logic          r_underrun;
  logic          r_misalign;
  rgb_t          r_rgb;

  logic          w_push;
  logic          w_pop;
  logic          w_show;
  logic          w_full;
  logic          w_empty;
  logic          w_vs_fall;
  logic          w_frame_start;
  logic          w_underrun;
  logic          w_misalign;
  logic          w_frame_done;
  logic [EW-1:0] w_head;
  logic          w_head_sof;
  rgb_t          w_head_rgb;

  assign s_ready    = ~w_full;
  assign w_push     = s_valid & ~w_full;
  assign w_head_sof = w_head[EW-1];
  assign w_head_rgb = w_head[EW-2:0];

  // r_vs doubles as the edge-detector history, so a fall is seen one cycle before armed rises.
  assign w_vs_fall     = r_vs & ~vs_i;
  assign w_frame_start = r_armed & blank_i;

  assign hs_o       = r_hs;
  assign vs_o       = r_vs;
  assign blank_o    = r_blank;
  assign rgb_o      = r_rgb;
  assign underrun_o = r_underrun;
  assign misalign_o = r_misalign;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (pixel_clk),
    .rst_n   (pixel_rst_n),
    .wr_en   (w_push),
    .wr_data ({s_sof, s_data}),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_show       = 1'b0;
    w_underrun   = 1'b0;
    w_misalign   = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      SYNC: begin
        if (!w_empty) begin
          if (w_head_sof) w_state_nxt = ARM;
          else            w_pop       = 1'b1;
        end
      end
      ARM: begin
        if (w_frame_start) begin
          w_state_nxt = RUN;
          w_pop       = 1'b1;
          w_show      = 1'b1;
        end
      end
      RUN: begin
        if (blank_i) begin
          if (w_empty) begin
            w_underrun  = 1'b1;
            w_state_nxt = STARVE;
          end else if (w_head_sof && (r_pix_cnt != '0)) begin
            // The early sof word stays queued so the next frame can start from it.
            w_misalign  = 1'b1;
            w_state_nxt = STARVE;
          end else begin
            w_pop  = 1'b1;
            w_show = 1'b1;
            if (r_pix_cnt == LAST_IDX) begin
              w_frame_done = 1'b1;
              w_state_nxt  = SYNC;
            end
          end
        end
      end
      STARVE: begin
        if (w_vs_fall) w_state_nxt = SYNC;
      end
      default: w_state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_pix_cnt  <= '0;
      r_armed    <= 1'b0;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_blank    <= 1'b0;
      r_rgb      <= '0;
      r_underrun <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if ((r_state == RUN) && (w_state_nxt != RUN)) begin
        r_pix_cnt <= '0;
      end else if (w_show) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end

      if (w_vs_fall)    r_armed <= 1'b1;
      else if (blank_i) r_armed <= 1'b0;

      r_hs       <= hs_i;
      r_vs       <= vs_i;
      r_blank    <= blank_i;
      r_underrun <= w_underrun;
      r_misalign <= w_misalign;

      if (!blank_i)    r_rgb <= '0;
      else if (w_show) r_rgb <= w_head_rgb;
      else             r_rgb <= FILL_RGB;
    end
  end

`ifdef VGA_PIXBUF_STATS_EN
  logic [15:0] r_underrun_cnt;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      r_underrun_cnt <= '0;
      r_frame_cnt    <= '0;
    end else begin
      if ((w_underrun || w_misalign) && (r_underrun_cnt != 16'hFFFF)) begin
        r_underrun_cnt <= r_underrun_cnt + 1'b1;
      end
      if (w_frame_done && (r_frame_cnt != 16'hFFFF)) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign underrun_cnt_o = r_underrun_cnt;
  assign frame_cnt_o    = r_frame_cnt;
`endif

endmodule

// File: doc/vga_pixel_buffer.md
# vga_pixel_buffer

Frame-aligned pixel buffer sitting directly upstream of the `vga` timing generator's pixel path. It accepts a valid/ready RGB stream with a start-of-frame marker, buffers it in a show-ahead FIFO, and emits one pixel per active cycle, aligned to the generator's `HS`/`VS`/`BLANK`. Sync signals are re-registered so that `rgb_o` and the sync outputs leave the block cycle-aligned. The block detects underruns and frame misalignment and recovers at the next frame boundary.

## Interface
Parameters:
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `DEPTH`, 1024, FIFO entries; must be a power of two, at least 2
- `FILL_RGB`, 24'h000000, colour driven during underrun

Ports:
- `pixel_clk`  in  1  single clock for the whole block
- `pixel_rst_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input pixel accepted when high with `s_valid`
- `s_data`  in  24  RGB pixel, R in [23:16]
- `s_sof`  in  1  marks the first pixel of a frame
- `hs_i`, `vs_i`  in  1 each  from the timing generator; active-low
- `blank_i`  in  1  from the timing generator; high marks an active pixel
- `hs_o`, `vs_o`, `blank_o`  out  1 each  `hs_i`, `vs_i` and `blank_i` delayed by 1 cycle
- `rgb_o`  out  24  pixel aligned with `blank_o`
- `underrun_o`  out  1  1-cycle pulse on the first starved active pixel
- `misalign_o`  out  1  1-cycle pulse when the head's `s_sof` disagrees with the frame position

## Operation
- FIFO entry is {sof, rgb}, 25 bits, in show-ahead mode.
- `s_ready = !full`. Push occurs when `s_valid && s_ready`. A push while full is impossible and needs no bypass.
- `frame_start` is the first cycle with `blank_i == 1` after a falling edge of `vs_i`. A registered edge detector plus an armed flag produce it.
- `pix_cnt` width is $clog2(HDISP*VDISP). It clears when leaving RUN.

FSM states:
- **SYNC** (reset state): pop every head with sof=0. When the FIFO is non-empty and the head has sof=1, go to ARM.
- **ARM**: no pops. On `frame_start`, go to RUN and pop the head in that same cycle.
- **RUN**: on each `blank_i == 1` cycle, pop the head and increment `pix_cnt`.
  - Popped head has sof=1 while `pix_cnt != 0`: pulse `misalign_o`, output `FILL_RGB`, go to STARVE. That pixel is not consumed.
  - Pop of pixel index HDISP*VDISP-1: go to SYNC. In the next cycle SYNC either moves straight to ARM or flushes stray words.
  - `blank_i == 1` with FIFO empty: output `FILL_RGB`, pulse `underrun_o`, go to STARVE.
- **STARVE**: no pops; every active pixel outputs `FILL_RGB`. On the next `vs_i` falling edge, go to SYNC.
- `rgb_o` is 0 whenever `blank_i` was 0.

## Timing
- All outputs are registered.
- Reset values: `hs_o`=1, `vs_o`=1, `blank_o`=0, `rgb_o`=0, `underrun_o`=0, `misalign_o`=0, `s_ready`=1 (FIFO empty), state SYNC, `pix_cnt`=0.
- Latency from `blank_i`/`hs_i`/`vs_i` to the outputs is exactly 1 cycle. `rgb_o` is valid in the same cycle as the matching `blank_o`.
- Input to output minimum latency: 2 cycles (push, then show-ahead head registered on pop).
- A reset assertion mid-frame drops all FIFO content immediately, asynchronously.
- A push and a pop in the same cycle leave the occupancy unchanged.
- `vs_i` falling edge and `blank_i == 1` in the same cycle: the edge is registered first, so `frame_start` occurs at the next active cycle.

## Configuration
- `VGA_PIXBUF_STATS_EN` defined: adds output ports `underrun_cnt_o` [15:0] and `frame_cnt_o` [15:0].
  - `underrun_cnt_o` counts `underrun_o` and `misalign_o` pulses.
  - `frame_cnt_o` counts completed frames.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `VGA_PIXBUF_STATS_EN` not defined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `vga_pkg`:
  - timing constants HFP=40, HPULSE=48, HBP=40, VFP=13, VPULSE=3, VBP=29
  - `rgb_t` (logic [23:0])
  - FSM enum `pixbuf_state_t` {SYNC, ARM, RUN, STARVE}
- Sub-module `sync_fifo`: parameters WIDTH and DEPTH, show-ahead, active-low asynchronous reset, `full`/`empty` outputs. Instantiated once.

## Test plan
- Reset, then a stream of 2 frames with HDISP=8, VDISP=4 and pixels 0..31 with sof on pixel 0, driven by a model of the timing generator -> `rgb_o` equals the pixel index on every `blank_o` cycle of both frames; no error pulses.
- The source stalls after 10 pixels of a frame -> on the 11th active cycle, `underrun_o` pulses and `rgb_o`=`FILL_RGB` for the rest of the frame; the next frame, sent complete, displays correctly.
- 5 garbage words without sof are pushed before the first sof -> all 5 are dropped in SYNC; the frame is displayed from pixel 0.
- A sof is injected at pixel index 7 -> `misalign_o` pulses at that cycle; the injected frame is displayed correctly from the next `vs_i` falling edge onward.
- `pixel_rst_n` is asserted mid-RUN with the FIFO holding 100 words -> all outputs return to their reset values asynchronously; `s_ready`=1 and the FIFO is empty on release.
- Continuous `s_valid` is held without any pops -> `s_ready` drops after exactly DEPTH accepts; no data is lost once display starts.
